// File: rtl/pipe_backend.sv
`default_nettype none
// ============================================================================
// Module      : pipe_backend
// Description : Output-side companion of the pipe frontend. Packs a module's
//               unpacked output stream (start/stop/data/valid, ready back to
//               the module) onto an outbound pipe bus through a two-entry
//               registered skid buffer. pipe_out valid/start/stop/data come
//               straight from the main register. out_ready is a decode of
//               the state register and reset only, so downstream ready never
//               reaches upstream logic combinationally.
// Ports       : clock     - clock, all state updates on posedge
//               reset     - synchronous, active-high reset
//               pipe_out  - outbound pipe; start/stop/data/valid driven here,
//                           ready sampled from downstream
//               out_start - first word of packet (qualified by out_valid)
//               out_stop  - last word of packet (qualified by out_valid)
//               out_data  - payload word
//               out_valid - module presents a word
//               out_ready - block accepts a word this cycle
// Pipe layout : [D-1:0] data, [D] start, [D+1] stop, [D+2] valid, [D+3] ready
//               where D = `P_Data_w(PipeSpec)
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef PS_d8
`define PS_d8 8
`endif
`ifndef P_Data_w
`define P_Data_w(ps) (ps)
`endif
`ifndef P_w
`define P_w(ps) ((ps) + 4)
`endif

module pipe_backend #(
    parameter int PipeSpec = `PS_d8
) (
    input  logic                          clock,
    input  logic                          reset,
    inout  wire  [`P_w(PipeSpec)-1:0]     pipe_out,
    input  logic                          out_start,
    input  logic                          out_stop,
    input  logic [`P_Data_w(PipeSpec)-1:0] out_data,
    input  logic                          out_valid,
    output logic                          out_ready
);

    localparam int D  = `P_Data_w(PipeSpec);
    localparam int PW = `P_w(PipeSpec);

    // Forward (block-driven) part of the pipe bus: everything below ready.
    function automatic logic [D+2:0] p_pack_fwd(input logic st, input logic sp,
                                                input logic [D-1:0] dat,
                                                input logic vld);
        return {vld, sp, st, dat};
    endfunction

    function automatic logic p_unpack_ready(input logic [PW-1:0] bus);
        return bus[D+3];
    endfunction

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // main empty, skid empty
        BUSY  = 2'd1,   // main full,  skid empty
        FULL  = 2'd2    // main full,  skid full
    } state_t;

    typedef struct packed {
        logic         start;
        logic         stop;
        logic [D-1:0] data;
        logic         valid;
    } word_t;

    state_t state_q;
    word_t  main_q;
    word_t  skid_q;
    word_t  in_word;

    logic pipe_ready;
    logic accept;
    logic drain;

    assign pipe_ready = p_unpack_ready(pipe_out);
    assign out_ready  = (state_q != FULL) & ~reset;
    assign accept     = out_valid & out_ready;
    assign drain      = main_q.valid & pipe_ready;

    assign in_word = '{start: out_start, stop: out_stop, data: out_data, valid: 1'b1};

    // Main register drives the bus directly; cleared entries are all-zero,
    // which gives the required idle value of start/stop/data.
    assign pipe_out[D+2:0] = p_pack_fwd(main_q.start, main_q.stop, main_q.data, main_q.valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= in_word;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && drain) begin
                        main_q <= in_word;
                    end else if (accept) begin
                        skid_q  <= in_word;
                        state_q <= FULL;
                    end else if (drain) begin
                        main_q  <= '0;
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    // out_ready is low here, so only a drain can happen.
                    if (drain) begin
                        main_q  <= skid_q;
                        skid_q  <= '0;
                        state_q <= BUSY;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
